// File: rtl/s2p_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s2p_rx : serial-to-parallel receiver with valid/ready output and overrun   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module s2p_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_fresh;
    logic             w_complete;

    // w_fresh is the register contents after sampling bit 0 of a new frame
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_sr[WIDTH-2:0], si};
            assign w_fresh   = {{(WIDTH-1){1'b0}}, si};
        end else begin : g_lsb_first
            assign w_shifted = {si, r_sr[WIDTH-1:1]};
            assign w_fresh   = {si, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = CW'(1);
                    w_sr_nxt    = w_fresh;
                end
            end
            S_SHIFT: begin
                if (start) begin
                    w_cnt_nxt = CW'(1);
                    w_sr_nxt  = w_fresh;
                end else if (r_cnt == C_LAST) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_sr_nxt    = w_shifted;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_sr_nxt  = w_shifted;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A completed word is dropped only if the previous one is still held unaccepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (w_complete) begin
            if (!po_valid || po_ready) begin
                po       <= w_sr_nxt;
                po_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (po_valid && po_ready) begin
            po_valid <= 1'b0;
        end
    end

    assign busy = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_s2p_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_s2p_rx : scoreboard bench, MSB-first and LSB-first receivers in parallel|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_s2p_rx;

    logic       clk = 1'b1;
    logic       rst_n;
    logic       start;
    logic       si;
    logic       po_ready;
    logic [3:0] po_m, po_l;
    logic       vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l;

    int checks   = 0;
    int failures = 0;

    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    s2p_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start), .si(si),
        .po(po_m), .po_valid(vld_m), .po_ready(po_ready),
        .busy(busy_m), .overrun(ovr_m)
    );

    s2p_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start), .si(si),
        .po(po_l), .po_valid(vld_l), .po_ready(po_ready),
        .busy(busy_l), .overrun(ovr_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream literal: leftmost bit is sent first
    task automatic send_frame(input logic [3:0] s, input bit keep);
        if (keep) begin
            q_m.push_back(s);
            q_l.push_back(rev4(s));
        end
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            si    = s[3-k];
            tick();
            chk("busy_m", 32'(busy_m), 32'(k < 3));
            chk("busy_l", 32'(busy_l), 32'(k < 3));
        end
        start = 1'b0;
        si    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every accepted word must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n) begin
            if (vld_m && po_ready) begin
                if (q_m.size() == 0) chk("unexpected_word_m", 32'(po_m), 32'hFFFF);
                else chk("word_m", 32'(po_m), 32'(q_m.pop_front()));
            end
            if (vld_l && po_ready) begin
                if (q_l.size() == 0) chk("unexpected_word_l", 32'(po_l), 32'hFFFF);
                else chk("word_l", 32'(po_l), 32'(q_l.pop_front()));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        si       = 1'b0;
        po_ready = 1'b0;

        // 1. reset state, then idle without start
        #2;
        chk("rst_po_m", 32'(po_m), 0);
        chk("rst_vld_m", 32'(vld_m), 0);
        chk("rst_busy_m", 32'(busy_m), 0);
        chk("rst_ovr_m", 32'(ovr_m), 0);
        chk("rst_vld_l", 32'(vld_l), 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_busy_m", 32'(busy_m), 0);
        chk("idle_vld_m", 32'(vld_m), 0);
        chk("idle_vld_l", 32'(vld_l), 0);

        // 2/3. one frame 1,0,1,0 with consumer ready
        po_ready = 1'b1;
        send_frame(4'b1010, 1'b1);
        chk("t2_vld_m", 32'(vld_m), 1);
        chk("t2_po_m", 32'(po_m), 32'hA);
        chk("t3_po_l", 32'(po_l), 32'h5);
        tick();
        chk("t2_vld_one_cycle_m", 32'(vld_m), 0);
        chk("t3_vld_one_cycle_l", 32'(vld_l), 0);
        chk("t2_po_hold_m", 32'(po_m), 32'hA);

        // 4. consumer stalled: second back-to-back word is dropped
        po_ready = 1'b0;
        send_frame(4'b1010, 1'b1);
        send_frame(4'b0110, 1'b0);
        chk("t4_vld_m", 32'(vld_m), 1);
        chk("t4_po_m", 32'(po_m), 32'hA);
        chk("t4_po_l", 32'(po_l), 32'h5);
        chk("t4_ovr_m", 32'(ovr_m), 1);
        chk("t4_ovr_l", 32'(ovr_l), 1);
        po_ready = 1'b1;
        tick();
        chk("t4_vld_clr_m", 32'(vld_m), 0);
        chk("t4_vld_clr_l", 32'(vld_l), 0);
        chk("t4_ovr_sticky_m", 32'(ovr_m), 1);
        tick();
        chk("t4_ovr_sticky2_m", 32'(ovr_m), 1);

        // 5. restart after two bits yields one word only
        do_reset();
        chk("t5_ovr_rst_m", 32'(ovr_m), 0);
        start = 1'b1; si = 1'b1; tick();
        start = 1'b0; si = 1'b1; tick();
        chk("t5_partial_vld_m", 32'(vld_m), 0);
        send_frame(4'b1100, 1'b1);
        chk("t5_po_m", 32'(po_m), 32'hC);
        chk("t5_po_l", 32'(po_l), 32'h3);
        chk("t5_ovr_m", 32'(ovr_m), 0);
        chk("t5_ovr_l", 32'(ovr_l), 0);
        tick();

        // 6. asynchronous reset mid-frame
        start = 1'b1; si = 1'b1; tick();
        start = 1'b0; si = 1'b1; tick();
        chk("t6_busy_pre_m", 32'(busy_m), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy_m", 32'(busy_m), 0);
        chk("t6_po_m", 32'(po_m), 0);
        chk("t6_po_l", 32'(po_l), 0);
        chk("t6_vld_m", 32'(vld_m), 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("t6_idle_busy_m", 32'(busy_m), 0);
        send_frame(4'b0011, 1'b1);
        chk("t6_po_after_m", 32'(po_m), 32'h3);
        chk("t6_po_after_l", 32'(po_l), 32'hC);
        tick();
        tick();

        chk("q_m_empty", 32'(q_m.size()), 0);
        chk("q_l_empty", 32'(q_l.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
